// File: rtl/sll_iterative.sv
// Multi-cycle logical left shifter: one barrel stage per clock (16, 8, 4, 2, 1),
// with a start/ready handshake so the ALU wrapper can stall while a shift runs.
module sll_iterative #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_shift,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_resultRDY,
  output logic               busy
);

  localparam int unsigned StageW = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
  localparam logic [StageW-1:0] StageLast = StageW'(SHAMT_W - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] shamt_q;
  logic [StageW-1:0]  stage_q;
  logic [WIDTH-1:0]   result_q;
  logic               rdy_q;
  logic               busy_q;

  // Work value after applying the current stage (holds when its shamt bit is 0).
  always_comb begin
    work_d = work_q;
    if (shamt_q[stage_q]) begin
      work_d = work_q << (WIDTH'(1) << stage_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      work_q   <= '0;
      shamt_q  <= '0;
      stage_q  <= '0;
      result_q <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (ctrl_shift) begin
            work_q  <= data_operandA;
            shamt_q <= ctrl_shiftamt;
            stage_q <= StageLast;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end else begin
            state_q <= StIdle;
          end
        end
        StShift: begin
          work_q <= work_d;
          if (stage_q == '0) begin
            result_q <= work_d;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StDone;
          end else begin
            stage_q <= stage_q - 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: doc/sll_iterative.md
Name: sll_iterative

Overview:
- Multi-cycle 32-bit logical left shifter for the processor ALU; it is the left-direction counterpart of the arithmetic right-shift stages.
- It applies one barrel stage per clock, in the order 16, 8, 4, 2, 1, each gated by the matching shamt bit.
- A start/ready handshake lets the ALU wrapper stall the pipeline while a shift is in progress.
- It keeps the per-stage logic small and is a drop-in for timing-critical builds, in place of the single-cycle shifter.

Parameters:
- WIDTH, 32, operand and result width.
- SHAMT_W, 5, shift-amount width; must satisfy 2^SHAMT_W == WIDTH.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- ctrl_shift  input  1  start request; sampled only in IDLE or DONE.
- data_operandA  input  WIDTH  value to shift; captured on an accepted start.
- ctrl_shiftamt  input  SHAMT_W  shift amount; captured on an accepted start.
- data_result  output  WIDTH  shifted result; holds its value until the next completion.
- data_resultRDY  output  1  single-cycle pulse; data_result is valid in that cycle.
- busy  output  1  high while in SHIFT.

Behaviour:
- Reset (async assert, any state):
  - state goes to IDLE.
  - data_result = 0, data_resultRDY = 0, busy = 0.
  - Internal work register, shamt register and stage counter are cleared.
  - An in-flight shift is discarded; no resultRDY pulse ever follows it.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If ctrl_shift = 1 at an edge: capture data_operandA into the work register and ctrl_shiftamt into the shamt register; set stage = SHAMT_W-1 (4); go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each edge:
  - If shamt[stage] = 1, the work register becomes work << 2^stage with zero fill; if it is 0, the work register holds.
  - If stage = 0: load data_result from the final work value and go to DONE. Otherwise stage decrements.
  - busy = 1 throughout SHIFT.
  - ctrl_shift is ignored while in SHIFT. No queuing, no error flag.
- DONE:
  - data_resultRDY = 1 for exactly this one cycle.
  - If ctrl_shift = 1 at this edge, the new operands are accepted and the state goes straight to SHIFT (back-to-back operation). Otherwise go to IDLE.
- Latency:
  - Start accepted at edge N; stages applied at edges N+1 through N+5.
  - data_resultRDY is high in the cycle after edge N+5.
  - Fixed at 5 cycles regardless of shamt; shamt = 0 is not short-circuited.
- Throughput: one shift per 6 cycles with back-to-back starts.
- Arithmetic:
  - Pure logical shift; vacated low bits are 0.
  - Bits shifted past the MSB are discarded.
  - No overflow detection.
- Output rules:
  - data_result changes only at the edge entering DONE.
  - Between completions it holds, including across IDLE and a subsequent SHIFT.
- Operand stability: inputs only need to be stable at the accepting edge. Later changes to data_operandA or ctrl_shiftamt must not affect the in-flight result.
- Reset mid-SHIFT followed by a new start: the result reflects only the new operands.

Test Plan:
- Basic shift: operandA = 0x0000_0001, shamt = 16, start pulse → data_resultRDY exactly 5 cycles after the accepting edge, data_result = 0x0001_0000; busy high for those 5 cycles.
- Extremes:
  - 0xFFFF_FFFF with shamt = 31 → 0x8000_0000.
  - 0x1234_5678 with shamt = 0 → 0x1234_5678, with the same 5-cycle latency.
- Mixed stages: 0x8000_00F1 with shamt = 5 (stages 4 and 1) → 0x0000_1E20, MSB dropped. Change data_operandA to 0xDEAD_BEEF on the cycle after the start → result unaffected.
- Start while busy:
  - Hold ctrl_shift high continuously with 0x0000_0003, shamt = 1; change the operands to 0x1, shamt = 4 mid-SHIFT → first result 0x0000_0006.
  - The DONE-cycle start is then accepted with the second operands → second result 0x0000_0010, 6 cycles after the first.
- Reset mid-operation:
  - Assert reset asynchronously (between edges) during stage 2 of 0xAAAA_AAAA, shamt = 8 → outputs go to 0 immediately and no resultRDY pulse follows.
  - New start with 0x0000_00FF, shamt = 8 → 0x0000_FF00.
- Hold check: after a completion with result 0x0000_0100, idle for 20 cycles → data_result stays 0x0000_0100 and data_resultRDY stays 0.
